vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync, blank and
// strobe decodes, plus an optional fixed delay line on the control outputs.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 12,
  parameter int DELAY    = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_ce,
  input  logic          en,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          vblank,
  output logic          line_start,
  output logic          frame_start
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (HT >= (1 << CW)) begin : g_ht_chk
    $error("vga_timing_gen: HT does not fit in CW bits");
  end
  if (VT >= (1 << CW)) begin : g_vt_chk
    $error("vga_timing_gen: VT does not fit in CW bits");
  end
  if (DELAY < 0 || DELAY > 7) begin : g_dly_chk
    $error("vga_timing_gen: DELAY must be in 0..7");
  end

  localparam logic [CW-1:0] HT_M1   = CW'(HT - 1);
  localparam logic [CW-1:0] VT_M1   = CW'(VT - 1);
  localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HS_ACT  = (HS_POL != 0);
  localparam logic          VS_ACT  = (VS_POL != 0);

  // Control bundle: [5]frame_start [4]line_start [3]vblank [2]video_on [1]vsync [0]hsync
  localparam logic [5:0] CTL_RST = {4'b0000, ~VS_ACT, ~HS_ACT};

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic [5:0]    ctl_q, ctl_d;
  logic [5:0]    ctl_o;

  function automatic logic [5:0] decode(input logic [CW-1:0] h, input logic [CW-1:0] v,
                                        input logic ls, input logic fs);
    logic hs_on, vs_on;
    hs_on = (h >= HS_BEG) && (h < HS_END);
    vs_on = (v >= VS_BEG) && (v < VS_END);
    return {fs, ls, (v >= V_ACT_C), (h < H_ACT_C) && (v < V_ACT_C),
            vs_on ? VS_ACT : ~VS_ACT, hs_on ? HS_ACT : ~HS_ACT};
  endfunction

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    ctl_d   = {2'b00, ctl_q[3:0]};
    if (!en) begin
      state_d = IDLE;
      h_d     = '0;
      v_d     = '0;
      ctl_d   = CTL_RST;
    end else if (pix_ce) begin
      if (state_q == IDLE) begin
        state_d = RUN;
        h_d     = '0;
        v_d     = '0;
        ctl_d   = decode('0, '0, 1'b1, 1'b1);
      end else begin
        if (h_q == HT_M1) begin
          h_d = '0;
          v_d = (v_q == VT_M1) ? '0 : v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
        end
        // Decodes follow the updated position so they line up with pixel_x/pixel_y.
        ctl_d = decode(h_d, v_d, (h_d == '0), (h_d == '0) && (v_d == '0));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
      ctl_q   <= CTL_RST;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      ctl_q   <= ctl_d;
    end
  end

  if (DELAY == 0) begin : g_nodly
    assign ctl_o = ctl_q;
  end else begin : g_dly
    logic [5:0] dly_q [DELAY];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DELAY; i++) dly_q[i] <= CTL_RST;
      end else if (!en) begin
        for (int i = 0; i < DELAY; i++) dly_q[i] <= CTL_RST;
      end else begin
        dly_q[0] <= ctl_q;
        for (int i = 1; i < DELAY; i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign ctl_o = dly_q[DELAY-1];
  end

  assign pixel_x = h_q;
  assign pixel_y = v_q;
  assign {frame_start, line_start, vblank, video_on, vsync, hsync} = ctl_o;

endmodule
